// File: rtl/mbus_sleep_arbiter.sv
// Sleep/wake arbiter for an MBus layer: guards a quiet bus before issuing sleep,
// waits for power-gate completion, and sequences the sleep-controller release on wakeup.
module mbus_sleep_arbiter #(
  parameter int GUARD_CYCLES = 4,
  parameter int WAKE_CYCLES  = 3,
  parameter int CNT_WIDTH    = 4
) (
  input  logic CLKIN,
  input  logic RESETn,
  input  logic SLEEP_REQ_BUS,
  input  logic SLEEP_REQ_LC,
  input  logic WAKEUP_REQ,
  input  logic BUS_BUSY,
  input  logic PG_DONE,
  output logic SLEEP_REQ,
  output logic SLEEP_CTRL_RSTn,
  output logic SLEEP_ACK_BUS,
  output logic SLEEP_ACK_LC,
  output logic WAKEUP_ACK,
  output logic ABORT,
  output logic ASLEEP
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GUARD,
    S_ISSUE,
    S_SLEEP,
    S_WAKE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] GUARD_LOAD = CNT_WIDTH'(GUARD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WAKE_LOAD  = CNT_WIDTH'(WAKE_CYCLES - 1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_grant_bus;
  logic                 r_grant_lc;
  logic                 r_wake_pend;
  logic                 r_sleep_req;
  logic                 r_ctrl_rstn;
  logic                 r_ack_bus;
  logic                 r_ack_lc;
  logic                 r_wakeup_ack;
  logic                 r_abort;
  logic                 r_asleep;

  logic w_req_any;
  logic w_granted_req;

  assign w_req_any     = SLEEP_REQ_BUS | SLEEP_REQ_LC;
  assign w_granted_req = (r_grant_bus & SLEEP_REQ_BUS) | (r_grant_lc & SLEEP_REQ_LC);

  always_ff @(posedge CLKIN or negedge RESETn) begin
    if (!RESETn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_grant_bus  <= 1'b0;
      r_grant_lc   <= 1'b0;
      r_wake_pend  <= 1'b0;
      r_sleep_req  <= 1'b0;
      r_ctrl_rstn  <= 1'b1;
      r_ack_bus    <= 1'b0;
      r_ack_lc     <= 1'b0;
      r_wakeup_ack <= 1'b0;
      r_abort      <= 1'b0;
      r_asleep     <= 1'b0;
    end else begin
      // Pulses are only ever set on a state transition, so they self-clear here.
      r_ack_bus    <= 1'b0;
      r_ack_lc     <= 1'b0;
      r_wakeup_ack <= 1'b0;
      r_abort      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_any && !WAKEUP_REQ && !BUS_BUSY) begin
            r_grant_bus <= SLEEP_REQ_BUS;
            r_grant_lc  <= ~SLEEP_REQ_BUS;
            r_cnt       <= GUARD_LOAD;
            r_state     <= S_GUARD;
          end
        end
        S_GUARD: begin
          if (WAKEUP_REQ || BUS_BUSY || !w_granted_req) begin
            r_abort     <= 1'b1;
            r_grant_bus <= 1'b0;
            r_grant_lc  <= 1'b0;
            r_state     <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_sleep_req <= 1'b1;
            r_wake_pend <= 1'b0;
            r_state     <= S_ISSUE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_ISSUE: begin
          // Committed: a wakeup seen here is remembered and served after power-gating.
          if (WAKEUP_REQ) r_wake_pend <= 1'b1;
          if (PG_DONE) begin
            r_sleep_req <= 1'b0;
            r_ctrl_rstn <= 1'b0;
            r_asleep    <= 1'b1;
            r_ack_bus   <= r_grant_bus;
            r_ack_lc    <= r_grant_lc;
            r_state     <= S_SLEEP;
          end
        end
        S_SLEEP: begin
          if (WAKEUP_REQ || r_wake_pend) begin
            r_wake_pend <= 1'b0;
            r_ctrl_rstn <= 1'b1;
            r_asleep    <= 1'b0;
            r_cnt       <= WAKE_LOAD;
            r_state     <= S_WAKE;
          end
        end
        S_WAKE: begin
          if (r_cnt == '0) begin
            r_wakeup_ack <= 1'b1;
            r_grant_bus  <= 1'b0;
            r_grant_lc   <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign SLEEP_REQ       = r_sleep_req;
  assign SLEEP_CTRL_RSTn = r_ctrl_rstn;
  assign SLEEP_ACK_BUS   = r_ack_bus;
  assign SLEEP_ACK_LC    = r_ack_lc;
  assign WAKEUP_ACK      = r_wakeup_ack;
  assign ABORT           = r_abort;
  assign ASLEEP          = r_asleep;

endmodule

// File: tb/tb_mbus_sleep_arbiter.sv
// Scoreboard bench for mbus_sleep_arbiter: stimulus pushes every expected output change
// with its cycle number; a negedge monitor pops and compares on each observed change.
module tb_mbus_sleep_arbiter;

  logic CLKIN = 1'b0;
  logic RESETn = 1'b0;
  logic SLEEP_REQ_BUS = 1'b0;
  logic SLEEP_REQ_LC = 1'b0;
  logic WAKEUP_REQ = 1'b0;
  logic BUS_BUSY = 1'b0;
  logic PG_DONE = 1'b0;
  logic SLEEP_REQ, SLEEP_CTRL_RSTn, SLEEP_ACK_BUS, SLEEP_ACK_LC, WAKEUP_ACK, ABORT, ASLEEP;

  mbus_sleep_arbiter #(.GUARD_CYCLES(4), .WAKE_CYCLES(3), .CNT_WIDTH(4)) dut (
    .CLKIN(CLKIN), .RESETn(RESETn),
    .SLEEP_REQ_BUS(SLEEP_REQ_BUS), .SLEEP_REQ_LC(SLEEP_REQ_LC),
    .WAKEUP_REQ(WAKEUP_REQ), .BUS_BUSY(BUS_BUSY), .PG_DONE(PG_DONE),
    .SLEEP_REQ(SLEEP_REQ), .SLEEP_CTRL_RSTn(SLEEP_CTRL_RSTn),
    .SLEEP_ACK_BUS(SLEEP_ACK_BUS), .SLEEP_ACK_LC(SLEEP_ACK_LC),
    .WAKEUP_ACK(WAKEUP_ACK), .ABORT(ABORT), .ASLEEP(ASLEEP)
  );

  always #5 CLKIN = ~CLKIN;

  // {SLEEP_REQ, SLEEP_CTRL_RSTn, ACK_BUS, ACK_LC, WAKEUP_ACK, ABORT, ASLEEP}
  localparam logic [6:0] V_IDLE     = 7'b0100000;
  localparam logic [6:0] V_ISSUE    = 7'b1100000;
  localparam logic [6:0] V_SLP_ABUS = 7'b0010001;
  localparam logic [6:0] V_SLP_ALC  = 7'b0001001;
  localparam logic [6:0] V_SLEEP    = 7'b0000001;
  localparam logic [6:0] V_WAKE     = 7'b0100000;
  localparam logic [6:0] V_WACK     = 7'b0100100;
  localparam logic [6:0] V_ABORT    = 7'b0100010;

  wire [6:0] outs = {SLEEP_REQ, SLEEP_CTRL_RSTn, SLEEP_ACK_BUS, SLEEP_ACK_LC,
                     WAKEUP_ACK, ABORT, ASLEEP};

  typedef struct {
    int         cyc;
    logic [6:0] vec;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic       mon_en = 1'b0;
  logic [6:0] prev;

  always @(posedge CLKIN) cyc <= cyc + 1;

  always @(negedge CLKIN) begin
    if (mon_en && (outs !== prev)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d got=%b wanted=no change (stays %b)", cyc, outs, prev);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.vec !== outs) begin
          bad++;
          $display("FAIL out_change got cyc=%0d vec=%b wanted cyc=%0d vec=%b", cyc, outs, e.cyc, e.vec);
        end else begin
          $display("ok cyc=%0d vec=%b", cyc, outs);
        end
      end
      prev = outs;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLKIN);
      #1;
    end
  endtask

  task automatic push_exp(input int d, input logic [6:0] v);
    sb.push_back('{cyc + d, v});
  endtask

  initial begin
    // Reset state
    step(3);
    total++;
    if (outs !== V_IDLE) begin
      bad++;
      $display("FAIL reset_state got=%b wanted=%b", outs, V_IDLE);
    end
    RESETn = 1'b1;
    prev = outs;
    mon_en = 1'b1;
    step(2);

    // BUS request, quiet bus: SLEEP_REQ 5 cycles later, PG_DONE -> ACK_BUS, then wake
    SLEEP_REQ_BUS = 1'b1;
    push_exp(5, V_ISSUE);
    step(7);
    PG_DONE = 1'b1;
    push_exp(1, V_SLP_ABUS);
    push_exp(2, V_SLEEP);
    step(1);
    PG_DONE = 1'b0;
    SLEEP_REQ_BUS = 1'b0;
    step(3);
    WAKEUP_REQ = 1'b1;
    push_exp(1, V_WAKE);
    push_exp(4, V_WACK);
    push_exp(5, V_IDLE);
    step(4);
    WAKEUP_REQ = 1'b0;
    step(4);

    // LC request, BUS_BUSY on 2nd guard cycle -> ABORT
    SLEEP_REQ_LC = 1'b1;
    push_exp(3, V_ABORT);
    push_exp(4, V_IDLE);
    step(2);
    BUS_BUSY = 1'b1;
    step(1);
    BUS_BUSY = 1'b0;
    SLEEP_REQ_LC = 1'b0;
    step(4);

    // Both requests: BUS wins; LC still high after wake is a fresh request
    SLEEP_REQ_BUS = 1'b1;
    SLEEP_REQ_LC = 1'b1;
    push_exp(5, V_ISSUE);
    step(6);
    PG_DONE = 1'b1;
    push_exp(1, V_SLP_ABUS);
    push_exp(2, V_SLEEP);
    step(1);
    PG_DONE = 1'b0;
    SLEEP_REQ_BUS = 1'b0;
    step(2);
    WAKEUP_REQ = 1'b1;
    push_exp(1, V_WAKE);
    push_exp(4, V_WACK);
    push_exp(5, V_IDLE);
    push_exp(9, V_ISSUE);
    step(4);
    WAKEUP_REQ = 1'b0;
    step(7);
    PG_DONE = 1'b1;
    push_exp(1, V_SLP_ALC);
    push_exp(2, V_SLEEP);
    step(1);
    PG_DONE = 1'b0;
    SLEEP_REQ_LC = 1'b0;
    step(2);
    WAKEUP_REQ = 1'b1;
    push_exp(1, V_WAKE);
    push_exp(4, V_WACK);
    push_exp(5, V_IDLE);
    step(4);
    WAKEUP_REQ = 1'b0;
    step(3);

    // WAKEUP_REQ during ISSUE: held until PG_DONE, one SLEEP cycle, then wake
    SLEEP_REQ_BUS = 1'b1;
    push_exp(5, V_ISSUE);
    step(6);
    WAKEUP_REQ = 1'b1;
    step(2);
    PG_DONE = 1'b1;
    push_exp(1, V_SLP_ABUS);
    push_exp(2, V_WAKE);
    push_exp(5, V_WACK);
    push_exp(6, V_IDLE);
    step(1);
    PG_DONE = 1'b0;
    SLEEP_REQ_BUS = 1'b0;
    step(4);
    WAKEUP_REQ = 1'b0;
    step(3);

    // PG_DONE in IDLE is ignored
    PG_DONE = 1'b1;
    step(1);
    PG_DONE = 1'b0;
    step(3);

    // Async reset while asleep: immediate return to reset values, no ACK
    SLEEP_REQ_BUS = 1'b1;
    push_exp(5, V_ISSUE);
    step(6);
    PG_DONE = 1'b1;
    push_exp(1, V_SLP_ABUS);
    push_exp(2, V_SLEEP);
    step(1);
    PG_DONE = 1'b0;
    SLEEP_REQ_BUS = 1'b0;
    step(3);
    RESETn = 1'b0;
    push_exp(0, V_IDLE);
    #1;
    total++;
    if (outs !== V_IDLE) begin
      bad++;
      $display("FAIL async_reset got=%b wanted=%b", outs, V_IDLE);
    end
    step(2);
    RESETn = 1'b1;
    step(5);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL missing_change got=none wanted cyc=%0d vec=%b", e.cyc, e.vec);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
